control_unit: RTL and testbench

//   Hardwired control sequencer for the Mini SRC datapath: owns the control-signal side of the datapath port.

---
 rtl/mini_src_pkg.sv | 68 ++++++
 rtl/control_unit_opcode_decoder.sv | 22 ++
 rtl/control_unit.sv | 170 +++++++++++++++++
 tb/tb_control_unit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mini_src_pkg.sv
// Shared constants and types for the Mini SRC control sequencer.
// Opcodes, bus-source codes, ALU codes, sequencer states and control bundle.
package mini_src_pkg;

   localparam logic [4:0] OP_BR   = 5'b01001;
   localparam logic [4:0] OP_JR   = 5'b01010;
   localparam logic [4:0] OP_JAL  = 5'b01011;
   localparam logic [4:0] OP_NOP  = 5'b11001;
   localparam logic [4:0] OP_HALT = 5'b11010;

   localparam logic [4:0] BUS_NONE = 5'b00000;
   localparam logic [4:0] BUS_PC   = 5'b10100;
   localparam logic [4:0] BUS_ZLOW = 5'b10011;
   localparam logic [4:0] BUS_MDR  = 5'b10101;
   localparam logic [4:0] BUS_C    = 5'b01100;

   localparam logic [3:0] ALU_NONE = 4'b0000;
   localparam logic [3:0] ALU_ADD  = 4'b0011;

   localparam logic [4:0] S_IDLE = 5'd0;
   localparam logic [4:0] F_T0   = 5'd1;
   localparam logic [4:0] F_T1   = 5'd2;
   localparam logic [4:0] F_T1W  = 5'd3;
   localparam logic [4:0] F_T2   = 5'd4;
   localparam logic [4:0] DEC    = 5'd5;
   localparam logic [4:0] BR_T3  = 5'd6;
   localparam logic [4:0] BR_T4  = 5'd7;
   localparam logic [4:0] BR_T5  = 5'd8;
   localparam logic [4:0] BR_T6  = 5'd9;
   localparam logic [4:0] JR_T3  = 5'd10;
   localparam logic [4:0] JAL_T3 = 5'd11;
   localparam logic [4:0] JAL_T4 = 5'd12;
   localparam logic [4:0] S_HALT = 5'd13;

   typedef struct packed {
      logic br;
      logic jr;
      logic jal;
      logic nop;
      logic halt;
      logic illegal;
   } op_class_t;

   // Only the controls this sequencer ever asserts; the rest are tied low in the top.
   typedef struct packed {
      logic       inc_pc;
      logic       e_pc;
      logic       e_ir;
      logic       e_y;
      logic       e_z;
      logic       e_mar;
      logic       e_mdr;
      logic       e_ra;
      logic       e_con_ff;
      logic       ram_read;
      logic       mdr_read;
      logic       gra;
      logic       e_rout;
      logic       imm_sel;
      logic [3:0] alu_op;
      logic [4:0] bus_sel;
   } ctrl_t;

   function automatic logic [4:0] opcode_of(input logic [31:0] ir);
      return ir[31:27];
   endfunction

endpackage

// File: rtl/control_unit_opcode_decoder.sv
// Classifies a 5-bit opcode into one-hot control-flow classes.
// Purely combinational, zero latency, no flow control.
module opcode_decoder
   import mini_src_pkg::*;
(
   input  logic [4:0] opcode,
   output op_class_t  op_class
);

   always_comb begin
      op_class = '0;
      case (opcode)
         OP_BR:   op_class.br      = 1'b1;
         OP_JR:   op_class.jr      = 1'b1;
         OP_JAL:  op_class.jal     = 1'b1;
         OP_NOP:  op_class.nop     = 1'b1;
         OP_HALT: op_class.halt    = 1'b1;
         default: op_class.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer: fetch, decode, control-flow execute for Mini SRC.
// Fetch takes 4+MEM_WAIT cycles to DEC; stop parks the sequencer in S_IDLE at an instruction boundary.
module control_unit
   import mini_src_pkg::*;
#(
   parameter int MEM_WAIT = 1
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        stop,
   input  logic [31:0] IR,
   input  logic        CON_out,
   output logic        incPC,
   output logic        e_PC,
   output logic        e_IR,
   output logic        e_Y,
   output logic        e_Z,
   output logic        e_MAR,
   output logic        e_MDR,
   output logic        e_RA,
   output logic        e_CON_FF,
   output logic        ram_read,
   output logic        ram_write,
   output logic        MDR_read,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        e_Rin,
   output logic        e_Rout,
   output logic        BAout,
   output logic        imm_sel,
   output logic [3:0]  ALU_op,
   output logic [4:0]  BusDataSelect,
   output logic        run,
   output logic        illegal_op
);

   localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

   logic [4:0]    state, nxt;
   logic [CW-1:0] wait_cnt;
   logic          wait_done;
   logic          illegal_q;
   op_class_t     op_class;
   ctrl_t         ctrl;
   logic          ir_unused;

   assign ir_unused = ^IR[26:0];
   assign wait_done = (wait_cnt == CW'(MEM_WAIT - 1));

   opcode_decoder u_dec (
      .opcode   (opcode_of(IR)),
      .op_class (op_class)
   );

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE: if (!stop) nxt = F_T0;
         F_T0:   nxt = F_T1;
         F_T1:   if (wait_done) nxt = F_T1W;
         F_T1W:  nxt = F_T2;
         F_T2:   nxt = DEC;
         DEC: begin
            nxt = S_IDLE;
            if (op_class.br)                           nxt = BR_T3;
            else if (op_class.jr)                      nxt = JR_T3;
            else if (op_class.jal)                     nxt = JAL_T3;
            else if (op_class.halt)                    nxt = S_HALT;
            else if (op_class.nop || op_class.illegal) nxt = S_IDLE;
         end
         BR_T3:  nxt = BR_T4;
         BR_T4:  nxt = BR_T5;
         BR_T5:  nxt = BR_T6;
         BR_T6:  nxt = S_IDLE;
         JR_T3:  nxt = S_IDLE;
         JAL_T3: nxt = JAL_T4;
         JAL_T4: nxt = S_IDLE;
         S_HALT: nxt = S_HALT;
         default: nxt = S_IDLE;
      endcase
   end

   // illegal_op is registered so it surfaces in the S_IDLE cycle after DEC, keeping IR off the output path.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state     <= S_IDLE;
         wait_cnt  <= '0;
         illegal_q <= 1'b0;
      end else begin
         state     <= nxt;
         wait_cnt  <= (state == F_T1 && !wait_done) ? wait_cnt + CW'(1) : '0;
         illegal_q <= (state == DEC) && op_class.illegal;
      end
   end

   always_comb begin
      ctrl = '0;
      case (state)
         F_T0: begin
            ctrl.bus_sel = BUS_PC;
            ctrl.e_mar   = 1'b1;
            ctrl.inc_pc  = 1'b1;
         end
         F_T1:  ctrl.ram_read = 1'b1;
         F_T1W: begin
            ctrl.mdr_read = 1'b1;
            ctrl.e_mdr    = 1'b1;
         end
         F_T2: begin
            ctrl.bus_sel = BUS_MDR;
            ctrl.e_ir    = 1'b1;
         end
         BR_T3: begin
            ctrl.gra      = 1'b1;
            ctrl.e_rout   = 1'b1;
            ctrl.e_con_ff = 1'b1;
         end
         BR_T4: begin
            ctrl.bus_sel = BUS_PC;
            ctrl.e_y     = 1'b1;
         end
         BR_T5: begin
            ctrl.bus_sel = BUS_C;
            ctrl.imm_sel = 1'b1;
            ctrl.alu_op  = ALU_ADD;
            ctrl.e_z     = 1'b1;
         end
         BR_T6: begin
            ctrl.bus_sel = BUS_ZLOW;
            ctrl.e_pc    = CON_out;
         end
         JR_T3, JAL_T4: begin
            ctrl.gra    = 1'b1;
            ctrl.e_rout = 1'b1;
            ctrl.e_pc   = 1'b1;
         end
         JAL_T3: begin
            ctrl.bus_sel = BUS_PC;
            ctrl.e_ra    = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

   assign incPC         = ctrl.inc_pc;
   assign e_PC          = ctrl.e_pc;
   assign e_IR          = ctrl.e_ir;
   assign e_Y           = ctrl.e_y;
   assign e_Z           = ctrl.e_z;
   assign e_MAR         = ctrl.e_mar;
   assign e_MDR         = ctrl.e_mdr;
   assign e_RA          = ctrl.e_ra;
   assign e_CON_FF      = ctrl.e_con_ff;
   assign ram_read      = ctrl.ram_read;
   assign ram_write     = 1'b0;
   assign MDR_read      = ctrl.mdr_read;
   assign Gra           = ctrl.gra;
   assign Grb           = 1'b0;
   assign Grc           = 1'b0;
   assign e_Rin         = 1'b0;
   assign e_Rout        = ctrl.e_rout;
   assign BAout         = 1'b0;
   assign imm_sel       = ctrl.imm_sel;
   assign ALU_op        = ctrl.alu_op;
   assign BusDataSelect = ctrl.bus_sel;
   assign run           = (state != S_HALT);
   assign illegal_op    = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle output vectors against hand-built expectations.
module tb_control_unit;

   logic        clock = 1'b0;
   logic        clear, stop, CON_out;
   logic [31:0] IR;
   logic        incPC, e_PC, e_IR, e_Y, e_Z, e_MAR, e_MDR, e_RA, e_CON_FF;
   logic        ram_read, ram_write, MDR_read, Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel;
   logic [3:0]  ALU_op;
   logic [4:0]  BusDataSelect;
   logic        run, illegal_op;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   control_unit #(.MEM_WAIT(1)) dut (
      .clock(clock), .clear(clear), .stop(stop), .IR(IR), .CON_out(CON_out),
      .incPC(incPC), .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .e_MAR(e_MAR),
      .e_MDR(e_MDR), .e_RA(e_RA), .e_CON_FF(e_CON_FF), .ram_read(ram_read),
      .ram_write(ram_write), .MDR_read(MDR_read), .Gra(Gra), .Grb(Grb), .Grc(Grc),
      .e_Rin(e_Rin), .e_Rout(e_Rout), .BAout(BAout), .imm_sel(imm_sel), .ALU_op(ALU_op),
      .BusDataSelect(BusDataSelect), .run(run), .illegal_op(illegal_op)
   );

   // Bit layout, MSB first: incPC..imm_sel (19 bits), ALU_op, BusDataSelect, run, illegal_op.
   logic [29:0] obs;
   assign obs = {incPC, e_PC, e_IR, e_Y, e_Z, e_MAR, e_MDR, e_RA, e_CON_FF, ram_read,
                 ram_write, MDR_read, Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel,
                 ALU_op, BusDataSelect, run, illegal_op};

   localparam logic [29:0] ILL   = 30'd1 << 0;
   localparam logic [29:0] RUN   = 30'd1 << 1;
   localparam logic [29:0] IMM   = 30'd1 << 11;
   localparam logic [29:0] ROUT  = 30'd1 << 13;
   localparam logic [29:0] GRA   = 30'd1 << 17;
   localparam logic [29:0] MDRR  = 30'd1 << 18;
   localparam logic [29:0] RREAD = 30'd1 << 20;
   localparam logic [29:0] ECON  = 30'd1 << 21;
   localparam logic [29:0] ERA   = 30'd1 << 22;
   localparam logic [29:0] EMDR  = 30'd1 << 23;
   localparam logic [29:0] EMAR  = 30'd1 << 24;
   localparam logic [29:0] EZ    = 30'd1 << 25;
   localparam logic [29:0] EY    = 30'd1 << 26;
   localparam logic [29:0] EIR   = 30'd1 << 27;
   localparam logic [29:0] EPC   = 30'd1 << 28;
   localparam logic [29:0] INC   = 30'd1 << 29;
   localparam logic [29:0] B_PC  = 30'b10100 << 2;
   localparam logic [29:0] B_ZL  = 30'b10011 << 2;
   localparam logic [29:0] B_MDR = 30'b10101 << 2;
   localparam logic [29:0] B_C   = 30'b01100 << 2;
   localparam logic [29:0] A_ADD = 30'b0011 << 7;

   localparam logic [29:0] V_IDLE = RUN;
   localparam logic [29:0] V_BR3  = RUN | GRA | ROUT | ECON;
   localparam logic [29:0] V_BR4  = RUN | B_PC | EY;
   localparam logic [29:0] V_BR5  = RUN | B_C | IMM | A_ADD | EZ;
   localparam logic [29:0] V_BR6  = RUN | B_ZL;
   localparam logic [29:0] V_JR3  = RUN | GRA | ROUT | EPC;
   localparam logic [29:0] V_JAL3 = RUN | B_PC | ERA;
   localparam logic [29:0] V_JAL4 = RUN | GRA | ROUT | EPC;

   localparam logic [29:0] FETCH [5] = '{
      RUN | INC | EMAR | B_PC,   // F_T0
      RUN | RREAD,               // F_T1
      RUN | MDRR | EMDR,         // F_T1W
      RUN | EIR | B_MDR,         // F_T2
      RUN                        // DEC
   };

   logic [29:0] exq[$];

   task automatic chk(input string tag, input logic [29:0] got, input logic [29:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%b want=%b", tag, got, want);
      end
   endtask

   task automatic fetch_chk(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         chk($sformatf("%s_f%0d", tag, i), obs, FETCH[i]);
      end
   endtask

   // Entered at a negedge with the DUT in S_IDLE; leaves at the negedge showing the post-instruction state.
   task automatic run_instr(input string tag, input logic [31:0] ir, input logic con,
                            input logic [29:0] tail);
      IR      = ir;
      CON_out = con;
      fetch_chk(tag, 5);
      foreach (exq[i]) begin
         @(negedge clock);
         chk($sformatf("%s_x%0d", tag, i), obs, exq[i]);
      end
      @(negedge clock);
      chk($sformatf("%s_end", tag), obs, tail);
   endtask

   initial begin
      clear   = 1'b1;
      stop    = 1'b0;
      CON_out = 1'b0;
      IR      = 32'h0;
      repeat (4) @(negedge clock);
      chk("rst_hold", obs, V_IDLE);
      @(negedge clock);
      clear = 1'b0;
      #1 chk("rst_release", obs, V_IDLE);

      exq = '{V_BR3, V_BR4, V_BR5, V_BR6 | EPC};
      run_instr("br_taken", 32'h48A80000, 1'b1, V_IDLE);
      exq = '{V_BR3, V_BR4, V_BR5, V_BR6};
      run_instr("br_not", 32'h48A80000, 1'b0, V_IDLE);
      exq = '{V_JAL3, V_JAL4};
      run_instr("jal", 32'h58800000, 1'b0, V_IDLE);
      exq = '{V_JR3};
      run_instr("jr", 32'h50800000, 1'b1, V_IDLE);
      exq = {};
      run_instr("nop", 32'hC8000000, 1'b0, V_IDLE);
      run_instr("illegal", 32'hF8000000, 1'b0, V_IDLE | ILL);
      run_instr("halt", 32'hD0000000, 1'b0, 30'd0);
      for (int i = 0; i < 19; i++) begin
         @(negedge clock);
         chk($sformatf("halt_hold%0d", i), obs, 30'd0);
      end
      clear = 1'b1;
      #1 chk("halt_clear", obs, V_IDLE);
      @(negedge clock);
      clear = 1'b0;
      chk("halt_release", obs, V_IDLE);

      // Clear mid-branch: outputs drop at once and the sequencer restarts from S_IDLE.
      IR      = 32'h48A80000;
      CON_out = 1'b1;
      fetch_chk("clr_br", 5);
      @(negedge clock);
      chk("clr_br_t3", obs, V_BR3);
      @(negedge clock);
      chk("clr_br_t4", obs, V_BR4);
      clear = 1'b1;
      #1 chk("clr_br_async", obs, V_IDLE);
      @(negedge clock);
      chk("clr_br_held", obs, V_IDLE);
      clear = 1'b0;

      // stop raised during F_T2: JR still completes, then the sequencer parks.
      IR = 32'h50800000;
      fetch_chk("stop", 4);
      stop = 1'b1;
      @(negedge clock);
      chk("stop_dec", obs, FETCH[4]);
      @(negedge clock);
      chk("stop_jr_t3", obs, V_JR3);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk($sformatf("stop_park%0d", i), obs, V_IDLE);
      end
      stop = 1'b0;
      @(negedge clock);
      chk("stop_resume", obs, FETCH[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
